// File: rtl/uart_bus_bridge_if.sv
// ============================================================================
// Module      : uart_bus_bridge_if
// Description : Byte handshake to the UART host FIFOs plus the single-word
//               register/memory bus driven by the command bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_bus_bridge_if #(
    parameter int ADDR_BYTES = 2
);
    // UART host byte interface
    logic [7:0]              uHByte;
    logic                    uHCanRead;
    logic                    uCRead;
    logic                    uHCanWrite;
    logic                    uCWrite;
    logic [7:0]              uCByte;
    // Register/memory bus
    logic [8*ADDR_BYTES-1:0] memAddr;
    logic [31:0]             memWData;
    logic                    memWrite;
    logic                    memRead;
    logic [31:0]             memRData;
    logic                    memReady;

    modport master (
        input  uHByte, uHCanRead, uHCanWrite, memRData, memReady,
        output uCRead, uCWrite, uCByte, memAddr, memWData, memWrite, memRead
    );

    modport slave (
        output uHByte, uHCanRead, uHCanWrite, memRData, memReady,
        input  uCRead, uCWrite, uCByte, memAddr, memWData, memWrite, memRead
    );
endinterface

`default_nettype wire

// File: rtl/uart_bus_bridge.sv
// ============================================================================
// Module      : uart_bus_bridge
// Description : Pops command frames from the UART RX FIFO, runs one bus read
//               or write per frame and pushes the response into the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_bridge #(
    parameter int ADDR_BYTES = 2,
    parameter int TIMEOUT    = 5_000_000,
    parameter int TWIDTH     = 23
) (
    input  wire logic         clock,
    input  wire logic         reset,
    uart_bus_bridge_if.master bus,
    output logic              hBusy,
    output logic              hError
);
    localparam int                AW        = 8 * ADDR_BYTES;
    localparam logic [7:0]        CMD_READ  = 8'h52;
    localparam logic [7:0]        CMD_WRITE = 8'h57;
    localparam logic [7:0]        RSP_ACK   = 8'h06;
    localparam logic [7:0]        RSP_NAK   = 8'h15;
    localparam logic [7:0]        ADDR_LAST = 8'(ADDR_BYTES - 1);
    localparam logic [TWIDTH-1:0] TMO_LAST  = TWIDTH'(TIMEOUT - 1);

    // The command byte is decoded in the same cycle it is accepted in IDLE,
    // so there is no separate resting state for it.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4,
        S_NAK  = 3'd5
    } state_t;

    state_t            state_q,    state_d;
    logic [7:0]        cnt_q,      cnt_d;
    logic [TWIDTH-1:0] tmo_q,      tmo_d;
    logic              is_write_q, is_write_d;
    logic [AW-1:0]     addr_sh_q,  addr_sh_d;
    logic [31:0]       data_sh_q,  data_sh_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic              uCRead_q,   uCRead_d;
    logic              uCWrite_q,  uCWrite_d;
    logic [7:0]        uCByte_q,   uCByte_d;
    logic [AW-1:0]     memAddr_q,  memAddr_d;
    logic [31:0]       memWData_q, memWData_d;
    logic              memWrite_q, memWrite_d;
    logic              memRead_q,  memRead_d;
    logic              hError_q,   hError_d;
    logic              rx_take;
    logic              tx_give;

    // Next-state, datapath and strobe generation for the frame sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        is_write_d = is_write_q;
        addr_sh_d  = addr_sh_q;
        data_sh_d  = data_sh_q;
        rdata_d    = rdata_q;
        uCRead_d   = 1'b0;
        uCWrite_d  = 1'b0;
        uCByte_d   = uCByte_q;
        memAddr_d  = memAddr_q;
        memWData_d = memWData_q;
        memWrite_d = memWrite_q;
        memRead_d  = memRead_q;
        hError_d   = 1'b0;
        // A strobe still high from last cycle blocks the next transfer,
        // which keeps pops and pushes at least two cycles apart.
        rx_take    = bus.uHCanRead && !uCRead_q;
        tx_give    = bus.uHCanWrite && !uCWrite_q;

        case (state_q)
            S_IDLE: begin
                if (rx_take) begin
                    uCRead_d = 1'b1;
                    cnt_d    = 8'd0;
                    tmo_d    = '0;
                    if (bus.uHByte == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = S_ADDR;
                    end else if (bus.uHByte == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = S_ADDR;
                    end else begin
                        state_d = S_NAK;
                    end
                end
            end
            S_ADDR: begin
                if (rx_take) begin
                    uCRead_d  = 1'b1;
                    tmo_d     = '0;
                    addr_sh_d = (addr_sh_q << 8) | AW'(bus.uHByte);
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = 8'd0;
                        if (is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d   = S_BUS;
                            memRead_d = 1'b1;
                            memAddr_d = addr_sh_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_IDLE;
                    hError_d  = 1'b1;
                    cnt_d     = 8'd0;
                    tmo_d     = '0;
                    addr_sh_d = '0;
                    data_sh_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_take) begin
                    uCRead_d  = 1'b1;
                    tmo_d     = '0;
                    data_sh_d = {data_sh_q[23:0], bus.uHByte};
                    if (cnt_q == 8'd3) begin
                        cnt_d      = 8'd0;
                        state_d    = S_BUS;
                        memWrite_d = 1'b1;
                        memAddr_d  = addr_sh_q;
                        memWData_d = data_sh_d;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_IDLE;
                    hError_d  = 1'b1;
                    cnt_d     = 8'd0;
                    tmo_d     = '0;
                    addr_sh_d = '0;
                    data_sh_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BUS: begin
                if (bus.memReady && (memRead_q || memWrite_q)) begin
                    if (memRead_q) begin
                        rdata_d = bus.memRData;
                    end
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_give) begin
                    uCWrite_d = 1'b1;
                    if (is_write_q) begin
                        uCByte_d = RSP_ACK;
                        state_d  = S_IDLE;
                    end else begin
                        // Read data leaves MSB first by shifting the capture left
                        uCByte_d = rdata_q[31:24];
                        rdata_d  = {rdata_q[23:0], 8'h00};
                        if (cnt_q == 8'd3) begin
                            cnt_d   = 8'd0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_NAK: begin
                if (tx_give) begin
                    uCWrite_d = 1'b1;
                    uCByte_d  = RSP_NAK;
                    hError_d  = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame or bus cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            tmo_q      <= '0;
            is_write_q <= 1'b0;
            addr_sh_q  <= '0;
            data_sh_q  <= '0;
            rdata_q    <= '0;
            uCRead_q   <= 1'b0;
            uCWrite_q  <= 1'b0;
            uCByte_q   <= 8'h00;
            memAddr_q  <= '0;
            memWData_q <= '0;
            memWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            hError_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            is_write_q <= is_write_d;
            addr_sh_q  <= addr_sh_d;
            data_sh_q  <= data_sh_d;
            rdata_q    <= rdata_d;
            uCRead_q   <= uCRead_d;
            uCWrite_q  <= uCWrite_d;
            uCByte_q   <= uCByte_d;
            memAddr_q  <= memAddr_d;
            memWData_q <= memWData_d;
            memWrite_q <= memWrite_d;
            memRead_q  <= memRead_d;
            hError_q   <= hError_d;
        end
    end

    assign bus.uCRead   = uCRead_q;
    assign bus.uCWrite  = uCWrite_q;
    assign bus.uCByte   = uCByte_q;
    assign bus.memAddr  = memAddr_q;
    assign bus.memWData = memWData_q;
    assign bus.memWrite = memWrite_q;
    assign bus.memRead  = memRead_q;
    assign hError       = hError_q;
    assign hBusy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
// ============================================================================
// Module      : tb_uart_bus_bridge
// Description : Directed self-checking bench for uart_bus_bridge with FIFO
//               and bus responder models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_bus_bridge;
    localparam int ADDR_BYTES = 2;
    localparam int TIMEOUT    = 100;
    localparam int TWIDTH     = 7;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic hBusy;
    logic hError;

    uart_bus_bridge_if #(.ADDR_BYTES(ADDR_BYTES)) bus_if ();

    uart_bus_bridge #(
        .ADDR_BYTES (ADDR_BYTES),
        .TIMEOUT    (TIMEOUT),
        .TWIDTH     (TWIDTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus_if),
        .hBusy  (hBusy),
        .hError (hError)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          passed = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    int          cyc = 0;
    int          last_rd = -10;
    int          last_wr = -10;
    int          spacing_err = 0;
    int          herr_cnt = 0;
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    int          strobe_cnt = 0;
    int          mem_lat = 1;
    logic        tx_ready = 1'b1;
    logic [31:0] rdata_val = 32'h0;
    logic [15:0] cap_addr = 16'h0;
    logic [31:0] cap_wdata = 32'h0;

    // FIFO models, bus responder and protocol monitors, all sampled mid-cycle
    always @(negedge clock) begin
        cyc++;
        if (bus_if.uCRead) begin
            if (cyc - last_rd < 2) spacing_err++;
            last_rd = cyc;
            if (rx_q.size() > 0) rx_q.delete(0);
        end
        if (bus_if.uCWrite) begin
            if (cyc - last_wr < 2) spacing_err++;
            last_wr = cyc;
            tx_log.push_back(bus_if.uCByte);
        end
        if (hError) herr_cnt++;
        if (bus_if.memWrite) wr_cycles++;
        if (bus_if.memRead) rd_cycles++;
        if (bus_if.memRead || bus_if.memWrite) begin
            cap_addr  = bus_if.memAddr;
            cap_wdata = bus_if.memWData;
            strobe_cnt++;
            if (strobe_cnt >= mem_lat) begin
                bus_if.memReady = 1'b1;
                bus_if.memRData = rdata_val;
            end
        end else begin
            strobe_cnt      = 0;
            bus_if.memReady = 1'b0;
        end
        bus_if.uHCanRead  = (rx_q.size() > 0);
        bus_if.uHByte     = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        bus_if.uHCanWrite = tx_ready;
    end

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        bus_if.uHCanRead = 1'b1;
        bus_if.uHByte    = rx_q[0];
    endtask

    task automatic set_tx_ready(input logic v);
        tx_ready          = v;
        bus_if.uHCanWrite = v;
    endtask

    task automatic wait_tx(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (tx_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if ({bus_if.uCRead, bus_if.uCWrite, bus_if.memRead, bus_if.memWrite} !== 4'b0) $display("FAIL reset_strobes: got %b expected 0000", {bus_if.uCRead, bus_if.uCWrite, bus_if.memRead, bus_if.memWrite}); else passed++;
        checks++; if ({bus_if.uCByte, bus_if.memAddr, bus_if.memWData} !== 56'h0) $display("FAIL reset_data: got %h expected 0", {bus_if.uCByte, bus_if.memAddr, bus_if.memWData}); else passed++;
        checks++; if ({hBusy, hError} !== 2'b00) $display("FAIL reset_status: got %b expected 00", {hBusy, hError}); else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_write();
        bit ok;
        int h0;
        tx_log.delete();
        wr_cycles = 0; rd_cycles = 0; mem_lat = 3; h0 = herr_cnt;
        push(8'h57); push(8'h12); push(8'h34);
        push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
        wait_tx(1, 200, ok);
        repeat (6) @(negedge clock);
        checks++; if (!ok) $display("FAIL write_tx_wait: got %0d bytes expected 1", tx_log.size()); else passed++;
        checks++; if (cap_addr !== 16'h1234) $display("FAIL write_addr: got %h expected 1234", cap_addr); else passed++;
        checks++; if (cap_wdata !== 32'hDEADBEEF) $display("FAIL write_wdata: got %h expected deadbeef", cap_wdata); else passed++;
        checks++; if (wr_cycles !== 3) $display("FAIL write_strobe_len: got %0d expected 3", wr_cycles); else passed++;
        checks++; if (rd_cycles !== 0) $display("FAIL write_no_read: got %0d expected 0", rd_cycles); else passed++;
        checks++; if (tx_log.size() !== 1) $display("FAIL write_tx_count: got %0d expected 1", tx_log.size()); else passed++;
        checks++; if (tx_log[0] !== 8'h06) $display("FAIL write_ack: got %h expected 06", tx_log[0]); else passed++;
        checks++; if ((herr_cnt - h0) !== 0 || hBusy !== 1'b0) $display("FAIL write_status: got herr %0d busy %b expected 0 0", herr_cnt - h0, hBusy); else passed++;
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] exp[4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        tx_log.delete();
        rd_cycles = 0; mem_lat = 1; rdata_val = 32'hCAFEF00D;
        push(8'h52); push(8'h00); push(8'h10);
        wait_tx(4, 200, ok);
        repeat (6) @(negedge clock);
        checks++; if (!ok || tx_log.size() !== 4) $display("FAIL read_tx_count: got %0d expected 4", tx_log.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_log[i] !== exp[i]) $display("FAIL read_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        checks++; if (cap_addr !== 16'h0010) $display("FAIL read_addr: got %h expected 0010", cap_addr); else passed++;
        checks++; if (rd_cycles !== 1) $display("FAIL read_strobe_len: got %0d expected 1", rd_cycles); else passed++;
        checks++; if (hBusy !== 1'b0) $display("FAIL read_busy_after: got %b expected 0", hBusy); else passed++;
    endtask

    task automatic test_nak();
        bit ok;
        int h0;
        logic [7:0] exp[5] = '{8'h15, 8'h12, 8'h34, 8'h56, 8'h78};
        tx_log.delete();
        mem_lat = 1; rdata_val = 32'h12345678; h0 = herr_cnt;
        push(8'h41); push(8'h52); push(8'h00); push(8'h10);
        wait_tx(5, 200, ok);
        repeat (6) @(negedge clock);
        checks++; if (!ok || tx_log.size() !== 5) $display("FAIL nak_tx_count: got %0d expected 5", tx_log.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_log[i] !== exp[i]) $display("FAIL nak_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        checks++; if ((herr_cnt - h0) !== 1) $display("FAIL nak_herror: got %0d pulses expected 1", herr_cnt - h0); else passed++;
        checks++; if (cap_addr !== 16'h0010) $display("FAIL nak_read_addr: got %h expected 0010", cap_addr); else passed++;
    endtask

    task automatic test_timeout();
        bit ok;
        int h0;
        logic [7:0] exp[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        tx_log.delete();
        h0 = herr_cnt;
        push(8'h57); push(8'h12);
        repeat (95) @(negedge clock);
        checks++; if ((herr_cnt - h0) !== 0) $display("FAIL timeout_early: got %0d pulses expected 0", herr_cnt - h0); else passed++;
        checks++; if (hBusy !== 1'b1) $display("FAIL timeout_busy_wait: got %b expected 1", hBusy); else passed++;
        repeat (35) @(negedge clock);
        checks++; if ((herr_cnt - h0) !== 1) $display("FAIL timeout_herror: got %0d pulses expected 1", herr_cnt - h0); else passed++;
        checks++; if (tx_log.size() !== 0) $display("FAIL timeout_no_tx: got %0d bytes expected 0", tx_log.size()); else passed++;
        checks++; if (hBusy !== 1'b0) $display("FAIL timeout_idle: got %b expected 0", hBusy); else passed++;
        mem_lat = 1; rdata_val = 32'h01020304;
        push(8'h52); push(8'h00); push(8'h20);
        wait_tx(4, 200, ok);
        repeat (6) @(negedge clock);
        checks++; if (!ok || tx_log.size() !== 4) $display("FAIL timeout_next_count: got %0d expected 4", tx_log.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_log[i] !== exp[i]) $display("FAIL timeout_next_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        checks++; if (cap_addr !== 16'h0020) $display("FAIL timeout_next_addr: got %h expected 0020", cap_addr); else passed++;
    endtask

    task automatic test_tx_stall();
        bit ok;
        logic [7:0] exp[4] = '{8'h89, 8'hAB, 8'hCD, 8'hEF};
        tx_log.delete();
        mem_lat = 1; rdata_val = 32'h89ABCDEF;
        set_tx_ready(1'b0);
        push(8'h52); push(8'h00); push(8'h30);
        repeat (60) @(negedge clock);
        checks++; if (tx_log.size() !== 0) $display("FAIL stall_no_push: got %0d bytes expected 0", tx_log.size()); else passed++;
        checks++; if (hBusy !== 1'b1 || rx_q.size() !== 0) $display("FAIL stall_state: got busy %b rxleft %0d expected 1 0", hBusy, rx_q.size()); else passed++;
        set_tx_ready(1'b1);
        wait_tx(4, 100, ok);
        repeat (8) @(negedge clock);
        checks++; if (!ok || tx_log.size() !== 4) $display("FAIL stall_tx_count: got %0d expected 4", tx_log.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_log[i] !== exp[i]) $display("FAIL stall_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        checks++; if (spacing_err !== 0) $display("FAIL strobe_spacing: got %0d violations expected 0", spacing_err); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp[5] = '{8'h06, 8'h13, 8'h57, 8'h9B, 8'hDF};
        tx_log.delete();
        mem_lat = 2; rdata_val = 32'h13579BDF;
        push(8'h57); push(8'hA5); push(8'h5A);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h52); push(8'h00); push(8'h40);
        wait_tx(5, 300, ok);
        repeat (6) @(negedge clock);
        checks++; if (!ok || tx_log.size() !== 5) $display("FAIL b2b_tx_count: got %0d expected 5", tx_log.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_log[i] !== exp[i]) $display("FAIL b2b_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        checks++; if (bus_if.memWData !== 32'h11223344) $display("FAIL b2b_wdata_hold: got %h expected 11223344", bus_if.memWData); else passed++;
        checks++; if (bus_if.memAddr !== 16'h0040) $display("FAIL b2b_addr_hold: got %h expected 0040", bus_if.memAddr); else passed++;
    endtask

    task automatic test_reset_in_bus();
        bit ok;
        bit seen;
        logic [7:0] exp[4] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
        tx_log.delete();
        mem_lat = 1000; seen = 1'b0;
        push(8'h52); push(8'h00); push(8'h50);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus_if.memRead) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) $display("FAIL rstbus_read_seen: got %b expected 1", seen); else passed++;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus_if.memRead !== 1'b0) $display("FAIL rstbus_memread: got %b expected 0", bus_if.memRead); else passed++;
        checks++; if ({bus_if.uCRead, bus_if.uCWrite, bus_if.memWrite, hBusy, hError} !== 5'b0) $display("FAIL rstbus_ctrl: got %b expected 00000", {bus_if.uCRead, bus_if.uCWrite, bus_if.memWrite, hBusy, hError}); else passed++;
        checks++; if ({bus_if.uCByte, bus_if.memAddr, bus_if.memWData} !== 56'h0) $display("FAIL rstbus_data: got %h expected 0", {bus_if.uCByte, bus_if.memAddr, bus_if.memWData}); else passed++;
        reset = 1'b0;
        mem_lat = 1; rdata_val = 32'h0F1E2D3C;
        repeat (2) @(negedge clock);
        push(8'h52); push(8'h00); push(8'h60);
        wait_tx(4, 200, ok);
        repeat (6) @(negedge clock);
        checks++; if (!ok || tx_log.size() !== 4) $display("FAIL rstbus_next_count: got %0d expected 4", tx_log.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tx_log[i] !== exp[i]) $display("FAIL rstbus_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        checks++; if (cap_addr !== 16'h0060) $display("FAIL rstbus_next_addr: got %h expected 0060", cap_addr); else passed++;
    endtask

    initial begin
        bus_if.uHByte     = 8'h00;
        bus_if.uHCanRead  = 1'b0;
        bus_if.uHCanWrite = 1'b1;
        bus_if.memRData   = 32'h0;
        bus_if.memReady   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_timeout();
        test_tx_stall();
        test_back_to_back();
        test_reset_in_bus();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
